// File: rtl/data_mem_dma_if.sv
// Bus bundle between the data-memory DMA engine and its surroundings:
// the CPU-side start/status handshake plus the shared data-memory port.
// The DMA engine connects through the slave modport; the CPU/memory
// side connects through the master modport.
interface data_mem_dma_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH       = 8
);
    logic                       dma_start;
    logic [DATA_ADDR_WIDTH-1:0] dma_src_addr;
    logic [DATA_ADDR_WIDTH-1:0] dma_dst_addr;
    logic [LEN_WIDTH-1:0]       dma_len;
    logic                       dma_fill_en;
    logic [DATA_WIDTH-1:0]      dma_fill_data;
    logic                       cpu_mem_req;
    logic [DATA_WIDTH-1:0]      data_mem_rdata;
    logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_raddr;
    logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_waddr;
    logic [DATA_WIDTH-1:0]      dma_data_mem_wdata;
    logic                       data_mem_read_ctrl_by;
    logic                       data_mem_write_ctrl_by;
    logic                       dma_mem_write;
    logic                       dma_busy;
    logic                       dma_done;
    logic                       dma_err;

    modport master (
        output dma_start, dma_src_addr, dma_dst_addr, dma_len,
               dma_fill_en, dma_fill_data, cpu_mem_req, data_mem_rdata,
        input  dma_data_mem_raddr, dma_data_mem_waddr, dma_data_mem_wdata,
               data_mem_read_ctrl_by, data_mem_write_ctrl_by, dma_mem_write,
               dma_busy, dma_done, dma_err
    );

    modport slave (
        input  dma_start, dma_src_addr, dma_dst_addr, dma_len,
               dma_fill_en, dma_fill_data, cpu_mem_req, data_mem_rdata,
        output dma_data_mem_raddr, dma_data_mem_waddr, dma_data_mem_wdata,
               data_mem_read_ctrl_by, data_mem_write_ctrl_by, dma_mem_write,
               dma_busy, dma_done, dma_err
    );
endinterface

// File: rtl/data_mem_dma.sv
// Data-memory DMA engine: copies a block of words (one read cycle then one
// write cycle per word) or fills a block with a constant (one write cycle
// per word). The CPU always wins the memory port; the engine simply stalls
// while cpu_mem_req is high. Out-of-range requests finish immediately with
// dma_err set and never touch memory.
module data_mem_dma #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 128,
    parameter int LEN_WIDTH       = 8
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    data_mem_dma_if.slave   bus
);
    localparam int EXT_WIDTH = DATA_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [LEN_WIDTH-1:0]       idx;
    logic [LEN_WIDTH-1:0]       len_reg;
    logic [DATA_ADDR_WIDTH-1:0] src_reg;
    logic [DATA_ADDR_WIDTH-1:0] dst_reg;
    logic                       fill_en_reg;
    logic [DATA_WIDTH-1:0]      fill_data_reg;
    logic [DATA_WIDTH-1:0]      buffer;
    logic                       err_reg;

    logic [EXT_WIDTH-1:0]       src_end;
    logic [EXT_WIDTH-1:0]       dst_end;
    logic                       range_fail;
    logic                       read_active;
    logic                       write_active;
    logic                       last_word;

    // End addresses are one bit wider than an address so a huge base plus
    // length cannot wrap around and sneak past the bounds check.
    assign src_end    = {1'b0, bus.dma_src_addr} + EXT_WIDTH'(bus.dma_len);
    assign dst_end    = {1'b0, bus.dma_dst_addr} + EXT_WIDTH'(bus.dma_len);
    assign range_fail = (!bus.dma_fill_en && (src_end > EXT_WIDTH'(NUM_WORDS)))
                      || (dst_end > EXT_WIDTH'(NUM_WORDS));

    assign read_active  = (state == READ)  && !bus.cpu_mem_req;
    assign write_active = (state == WRITE) && !bus.cpu_mem_req;
    assign last_word    = (idx == (len_reg - LEN_WIDTH'(1)));

    // State register.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a CPU request freezes the engine in READ or WRITE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.dma_start) begin
                    if ((bus.dma_len == '0) || range_fail) begin
                        next_state = DONE;
                    end else if (bus.dma_fill_en) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                if (!bus.cpu_mem_req) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (!bus.cpu_mem_req) begin
                    if (last_word) begin
                        next_state = DONE;
                    end else if (fill_en_reg) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Captured request, word index and read buffer.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            idx           <= '0;
            len_reg       <= '0;
            src_reg       <= '0;
            dst_reg       <= '0;
            fill_en_reg   <= 1'b0;
            fill_data_reg <= '0;
            buffer        <= '0;
            err_reg       <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.dma_start) begin
                idx           <= '0;
                len_reg       <= bus.dma_len;
                src_reg       <= bus.dma_src_addr;
                dst_reg       <= bus.dma_dst_addr;
                fill_en_reg   <= bus.dma_fill_en;
                fill_data_reg <= bus.dma_fill_data;
                err_reg       <= range_fail;
            end
            if (read_active) begin
                buffer <= bus.data_mem_rdata;
            end
            if (write_active && !last_word) begin
                idx <= idx + LEN_WIDTH'(1);
            end
        end
    end

    // Outputs: memory port is driven only during a cycle that actually
    // moves data, and everything is held at zero while reset is asserted.
    always_comb begin
        bus.dma_data_mem_raddr     = '0;
        bus.dma_data_mem_waddr     = '0;
        bus.dma_data_mem_wdata     = '0;
        bus.data_mem_read_ctrl_by  = 1'b0;
        bus.data_mem_write_ctrl_by = 1'b0;
        bus.dma_mem_write          = 1'b0;
        bus.dma_busy               = 1'b0;
        bus.dma_done               = 1'b0;
        bus.dma_err                = 1'b0;
        if (!cpu_rst) begin
            bus.dma_busy = (state != IDLE);
            bus.dma_done = (state == DONE);
            bus.dma_err  = (state == DONE) && err_reg;
            if (read_active) begin
                bus.data_mem_read_ctrl_by = 1'b1;
                bus.dma_data_mem_raddr    = src_reg + DATA_ADDR_WIDTH'(idx);
            end
            if (write_active) begin
                bus.data_mem_write_ctrl_by = 1'b1;
                bus.dma_mem_write          = 1'b1;
                bus.dma_data_mem_waddr     = dst_reg + DATA_ADDR_WIDTH'(idx);
                bus.dma_data_mem_wdata     = fill_en_reg ? fill_data_reg : buffer;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_dma.sv
// Directed testbench for data_mem_dma: a 128-word memory model sits on the
// DMA port, each scenario task drives a transfer and checks latency, flags
// and memory contents against hand-computed values.
module tb_data_mem_dma;
    logic cpu_clk = 1'b0;
    logic cpu_rst;

    int vectors    = 0;
    int miscompares = 0;
    int write_pulses = 0;
    int done_pulses  = 0;

    logic [31:0] mem [0:127];

    data_mem_dma_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32), .LEN_WIDTH(8)) bus ();

    data_mem_dma #(
        .DATA_WIDTH(32),
        .DATA_ADDR_WIDTH(32),
        .NUM_WORDS(128),
        .LEN_WIDTH(8)
    ) dut (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .bus(bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Combinational read port of the memory model.
    assign bus.data_mem_rdata = (bus.dma_data_mem_raddr < 32'd128)
                              ? mem[bus.dma_data_mem_raddr[6:0]] : 32'h0;

    // Memory write port plus write/done pulse counters.
    always @(posedge cpu_clk) begin
        if (bus.dma_mem_write) begin
            mem[bus.dma_data_mem_waddr[6:0]] <= bus.dma_data_mem_wdata;
            write_pulses <= write_pulses + 1;
        end
        if (bus.dma_done) begin
            done_pulses <= done_pulses + 1;
        end
    end

    // Drive one start pulse; returns just after the edge that samples it.
    task automatic start_dma(input logic [31:0] src, input logic [31:0] dst,
                             input logic [7:0] len, input logic fill,
                             input logic [31:0] fdata);
        @(posedge cpu_clk); #1;
        bus.dma_src_addr  = src;
        bus.dma_dst_addr  = dst;
        bus.dma_len       = len;
        bus.dma_fill_en   = fill;
        bus.dma_fill_data = fdata;
        bus.dma_start     = 1'b1;
        @(posedge cpu_clk); #1;
        bus.dma_start     = 1'b0;
    endtask

    // Count cycles from the start edge until dma_done; -1 on timeout.
    task automatic wait_done(input int budget, output int lat, output logic err_at_done);
        lat = 0;
        err_at_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge cpu_clk);
            lat++;
            if (bus.dma_done) begin
                err_at_done = bus.dma_err;
                return;
            end
        end
        lat = -1;
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        vectors++;
        if ({bus.dma_busy, bus.dma_done, bus.dma_err, bus.data_mem_read_ctrl_by,
             bus.data_mem_write_ctrl_by, bus.dma_mem_write} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got=%b want=000000",
                     {bus.dma_busy, bus.dma_done, bus.dma_err, bus.data_mem_read_ctrl_by,
                      bus.data_mem_write_ctrl_by, bus.dma_mem_write});
        end
        vectors++;
        if ({bus.dma_data_mem_raddr, bus.dma_data_mem_waddr, bus.dma_data_mem_wdata} !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_buses raddr=%h waddr=%h wdata=%h want 0",
                     bus.dma_data_mem_raddr, bus.dma_data_mem_waddr, bus.dma_data_mem_wdata);
        end
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        vectors++;
        if (bus.dma_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_busy got=%b want=0", bus.dma_busy);
        end
    endtask

    task automatic test_copy();
        int lat;
        logic err;
        int w0;
        for (int i = 0; i < 4; i++) begin
            mem[i]      = 32'hA000_0000 + 32'(i);
            mem[20 + i] = 32'h0;
        end
        w0 = write_pulses;
        start_dma(32'd0, 32'd20, 8'd4, 1'b0, 32'h0);
        wait_done(40, lat, err);
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("[TB] FAIL copy_latency got=%0d want=9", lat);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL copy_err got=%b want=0", err);
        end
        @(posedge cpu_clk); #1;
        vectors++;
        if ({bus.dma_busy, bus.dma_done} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL copy_back_idle busy,done got=%b want=00", {bus.dma_busy, bus.dma_done});
        end
        vectors++;
        if (write_pulses - w0 !== 4) begin
            miscompares++;
            $display("[TB] FAIL copy_writes got=%0d want=4", write_pulses - w0);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[20 + i] !== 32'hA000_0000 + 32'(i)) begin
                miscompares++;
                $display("[TB] FAIL copy_data[%0d] got=%h want=%h", 20 + i, mem[20 + i],
                         32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_fill();
        int lat;
        logic err;
        int w0;
        w0 = write_pulses;
        start_dma(32'd0, 32'd40, 8'd3, 1'b1, 32'hDEAD_BEEF);
        wait_done(40, lat, err);
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("[TB] FAIL fill_latency got=%0d want=4", lat);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL fill_err got=%b want=0", err);
        end
        @(posedge cpu_clk); #1;
        vectors++;
        if (write_pulses - w0 !== 3) begin
            miscompares++;
            $display("[TB] FAIL fill_writes got=%0d want=3", write_pulses - w0);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mem[40 + i] !== 32'hDEAD_BEEF) begin
                miscompares++;
                $display("[TB] FAIL fill_data[%0d] got=%h want=deadbeef", 40 + i, mem[40 + i]);
            end
        end
        vectors++;
        if (mem[43] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL fill_overrun mem[43] got=%h want=0", mem[43]);
        end
    endtask

    task automatic test_contention();
        int lat;
        logic seen_done;
        mem[60] = 32'h1111_2222;
        mem[61] = 32'h3333_4444;
        mem[70] = 32'h0;
        mem[71] = 32'h0;
        seen_done = 1'b0;
        start_dma(32'd60, 32'd70, 8'd2, 1'b0, 32'h0);
        lat = 1;
        while (lat <= 30) begin
            bus.cpu_mem_req = (lat >= 3) && (lat <= 5);
            @(negedge cpu_clk);
            if (bus.dma_done) begin
                seen_done = 1'b1;
                break;
            end
            if (lat == 1) begin
                vectors++;
                if ({bus.data_mem_read_ctrl_by, bus.dma_data_mem_raddr} !== {1'b1, 32'd60}) begin
                    miscompares++;
                    $display("[TB] FAIL first_read ctrl=%b raddr=%0d want ctrl=1 raddr=60",
                             bus.data_mem_read_ctrl_by, bus.dma_data_mem_raddr);
                end
            end
            if (bus.cpu_mem_req) begin
                vectors++;
                if ({bus.data_mem_read_ctrl_by, bus.data_mem_write_ctrl_by, bus.dma_mem_write,
                     bus.dma_data_mem_raddr, bus.dma_busy} !== {3'b000, 32'd0, 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL stall_cycle%0d rcb=%b wcb=%b we=%b raddr=%0d busy=%b want 0,0,0,0,1",
                             lat, bus.data_mem_read_ctrl_by, bus.data_mem_write_ctrl_by,
                             bus.dma_mem_write, bus.dma_data_mem_raddr, bus.dma_busy);
                end
            end
            @(posedge cpu_clk); #1;
            lat++;
        end
        bus.cpu_mem_req = 1'b0;
        vectors++;
        if (!seen_done || lat !== 8) begin
            miscompares++;
            $display("[TB] FAIL contention_latency got=%0d done=%b want=8", lat, seen_done);
        end
        @(posedge cpu_clk); #1;
        vectors++;
        if ({mem[70], mem[71]} !== {32'h1111_2222, 32'h3333_4444}) begin
            miscompares++;
            $display("[TB] FAIL contention_data got=%h,%h want=11112222,33334444", mem[70], mem[71]);
        end
    endtask

    task automatic test_range_err();
        int lat;
        logic err;
        int w0;
        w0 = write_pulses;
        start_dma(32'd126, 32'd0, 8'd4, 1'b0, 32'h0);
        wait_done(20, lat, err);
        vectors++;
        if (lat !== 1 || err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL range_err latency=%0d err=%b want latency=1 err=1", lat, err);
        end
        @(posedge cpu_clk); #1;
        @(negedge cpu_clk);
        vectors++;
        if (bus.dma_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_after_done got=%b want=0", bus.dma_err);
        end
        vectors++;
        if (write_pulses - w0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL range_err_writes got=%0d want=0", write_pulses - w0);
        end
    endtask

    task automatic test_len_zero();
        int lat;
        logic err;
        int w0;
        w0 = write_pulses;
        start_dma(32'd5, 32'd50, 8'd0, 1'b0, 32'h0);
        wait_done(20, lat, err);
        vectors++;
        if (lat !== 1 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL len_zero latency=%0d err=%b want latency=1 err=0", lat, err);
        end
        @(posedge cpu_clk); #1;
        vectors++;
        if (write_pulses - w0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL len_zero_writes got=%0d want=0", write_pulses - w0);
        end
    endtask

    task automatic test_busy_ignore_and_reset();
        int lat;
        int w0;
        int d0;
        for (int i = 0; i < 4; i++) begin
            mem[80 + i] = 32'h0;
        end
        mem[100] = 32'h0;
        w0 = write_pulses;
        d0 = done_pulses;
        start_dma(32'd0, 32'd80, 8'd4, 1'b0, 32'h0);
        lat = 1;
        while (lat < 5) begin
            bus.dma_start = (lat == 2);
            if (lat == 2) begin
                bus.dma_dst_addr = 32'd100;
                bus.dma_fill_en  = 1'b1;
            end
            @(negedge cpu_clk);
            if (lat == 4) begin
                vectors++;
                if ({bus.dma_mem_write, bus.dma_data_mem_waddr} !== {1'b1, 32'd81}) begin
                    miscompares++;
                    $display("[TB] FAIL second_write we=%b waddr=%0d want we=1 waddr=81",
                             bus.dma_mem_write, bus.dma_data_mem_waddr);
                end
            end
            @(posedge cpu_clk); #1;
            lat++;
        end
        bus.dma_start = 1'b0;
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        vectors++;
        if ({bus.dma_busy, bus.dma_done, bus.dma_err, bus.data_mem_read_ctrl_by,
             bus.data_mem_write_ctrl_by, bus.dma_mem_write, bus.dma_data_mem_raddr} !== 38'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs busy=%b done=%b rcb=%b we=%b raddr=%0d want all 0",
                     bus.dma_busy, bus.dma_done, bus.data_mem_read_ctrl_by,
                     bus.dma_mem_write, bus.dma_data_mem_raddr);
        end
        @(posedge cpu_clk); #1;
        cpu_rst = 1'b0;
        repeat (10) @(posedge cpu_clk);
        @(negedge cpu_clk);
        vectors++;
        if (bus.dma_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_idle busy got=%b want=0", bus.dma_busy);
        end
        vectors++;
        if (write_pulses - w0 !== 2 || done_pulses - d0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_counts writes=%0d dones=%0d want writes=2 dones=0",
                     write_pulses - w0, done_pulses - d0);
        end
        vectors++;
        if ({mem[80], mem[81], mem[82], mem[83], mem[100]} !==
            {32'hA000_0000, 32'hA000_0001, 32'h0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL midreset_mem got=%h %h %h %h m100=%h want=a0000000 a0000001 0 0 0",
                     mem[80], mem[81], mem[82], mem[83], mem[100]);
        end
    endtask

    // Scenario sequence.
    initial begin
        cpu_rst           = 1'b1;
        bus.dma_start     = 1'b0;
        bus.dma_src_addr  = 32'h0;
        bus.dma_dst_addr  = 32'h0;
        bus.dma_len       = 8'h0;
        bus.dma_fill_en   = 1'b0;
        bus.dma_fill_data = 32'h0;
        bus.cpu_mem_req   = 1'b0;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'h0;
        end
        test_reset();
        test_copy();
        test_fill();
        test_contention();
        test_range_err();
        test_len_zero();
        test_busy_ignore_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_mem_dma.md
DATA_MEM_DMA -- requirements
Module: data_mem_dma

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 The module SHALL have parameter DATA_ADDR_WIDTH, default 32, word-address width.
REQ-003 The module SHALL have parameter NUM_WORDS, default 128, data memory depth in words.
REQ-004 The module SHALL have parameter LEN_WIDTH, default 8, transfer length width.
REQ-005 The module SHALL have port cpu_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port cpu_rst, input, 1, reset that is synchronous and active-high.
REQ-007 The module SHALL have port dma_start, input, 1, start pulse, sampled only in IDLE.
REQ-008 The module SHALL have ports dma_src_addr and dma_dst_addr, input, DATA_ADDR_WIDTH each, word addresses, captured at start.
REQ-009 The module SHALL have port dma_len, input, LEN_WIDTH, word count, captured at start.
REQ-010 The module SHALL have port dma_fill_en, input, 1; when high, dma_fill_data is written instead of copying; captured at start.
REQ-011 The module SHALL have port dma_fill_data, input, DATA_WIDTH, captured at start.
REQ-012 The module SHALL have port cpu_mem_req, input, 1; the CPU needs data memory this cycle and has priority.
REQ-013 The module SHALL have port data_mem_rdata, input, DATA_WIDTH, memory read data, combinational from dma_data_mem_raddr in the same cycle.
REQ-014 The module SHALL have port dma_data_mem_raddr, output, DATA_ADDR_WIDTH, word read address.
REQ-015 The module SHALL have ports dma_data_mem_waddr and dma_data_mem_wdata, output, DATA_ADDR_WIDTH and DATA_WIDTH, word write address and data.
REQ-016 The module SHALL have ports data_mem_read_ctrl_by and data_mem_write_ctrl_by, output, 1 each; 0 selects the CPU and 1 selects DMA.
REQ-017 The module SHALL have port dma_mem_write, output, 1, write enable that the top level ORs into data_mem_write.
REQ-018 The module SHALL have ports dma_busy, dma_done and dma_err, output, 1 each: busy level, one-cycle completion pulse, and error flag valid with dma_done.

Function
REQ-019 The module SHALL implement states IDLE, READ, WRITE and DONE.
REQ-020 In IDLE with dma_start=1, the module SHALL capture all start inputs and clear the word index idx to 0.
REQ-021 From IDLE on start, the next state SHALL be DONE if len=0, or if the range check fails (src+len>NUM_WORDS when not filling, or dst+len>NUM_WORDS), computed at DATA_ADDR_WIDTH+1 bits with no wrap.
REQ-022 Otherwise the next state SHALL be WRITE when fill_en=1, else READ.
REQ-023 A range-check failure SHALL set dma_err=1 in the DONE cycle and SHALL perform no memory write.
REQ-024 In READ with cpu_mem_req=0, the module SHALL set read_ctrl_by=1 and raddr=src+idx, register data_mem_rdata into a word buffer at the edge, and go to WRITE.
REQ-025 In WRITE with cpu_mem_req=0, the module SHALL set write_ctrl_by=1, waddr=dst+idx, wdata=buffer (or fill_data), and dma_mem_write=1 for exactly that cycle.
REQ-026 After a WRITE cycle, the module SHALL go to DONE if idx=len-1, else increment idx and go to READ (copy) or stay in WRITE (fill).
REQ-027 In READ or WRITE with cpu_mem_req=1, the module SHALL hold state, idx and buffer, drive both ctrl_by=0 and dma_mem_write=0, and make no progress.
REQ-028 In every state other than an active READ or WRITE cycle, both ctrl_by outputs and dma_mem_write SHALL be 0, and all address and data outputs SHALL be 0.
REQ-029 DONE SHALL last one cycle with dma_done=1, then return to IDLE; dma_err SHALL be 0 outside DONE.
REQ-030 dma_busy SHALL be 1 in READ, WRITE and DONE, and 0 in IDLE.
REQ-031 dma_start SHALL be ignored when not in IDLE.
REQ-032 Copies SHALL proceed in ascending address order; overlapping ranges with dst>src SHALL replicate source words, and this is defined behaviour.
REQ-033 Latency without contention, with start sampled at edge t, SHALL be: dma_done high in cycle t+1+2N for a copy, t+1+N for a fill, and t+1 for len=0 or error.

Reset
REQ-034 When cpu_rst=1 at a clock edge, the module SHALL go to IDLE and clear idx, the buffer and all captured registers.
REQ-035 During reset, every output SHALL be 0.
REQ-036 Reset mid-transfer SHALL abort immediately; no dma_done pulse and no further write SHALL follow, and words already written SHALL remain.

Verification
REQ-037 The bench SHALL cover copy: mem[0..3]=A0..A3, src=0, dst=20, len=4, no contention -> mem[20..23]=A0..A3, dma_done at t+9, dma_err=0.
REQ-038 The bench SHALL cover fill: dst=40, len=3, fill_data=0xDEADBEEF -> mem[40..42]=0xDEADBEEF, 3 write pulses, dma_done at t+4.
REQ-039 The bench SHALL cover contention: copy with len=2 and cpu_mem_req=1 for 3 cycles mid-READ -> ctrl_by=0 during those cycles, correct data, dma_done delayed by exactly 3 cycles.
REQ-040 The bench SHALL cover range error: src=126, len=4 -> dma_done and dma_err at t+1, no dma_mem_write.
REQ-041 The bench SHALL cover len=0 -> dma_done at t+1 with dma_err=0.
REQ-042 The bench SHALL cover start ignored while busy and reset mid-transfer: cpu_rst after the 2nd write of len=4 -> IDLE, only 2 words written, no dma_done.
